// File: rtl/irrigation_zone_controller.sv
// Multi-zone irrigation controller: round-robin zone grant, reservoir level tracking, refill and cleaning.
// Optional grant timeout enabled by defining IRRIG_TIMEOUT_EN.
module irrigation_zone_controller #(
    parameter int ZONES        = 4,
    parameter int LEVEL_W      = 3,
    parameter int LEVEL_INIT   = 2**LEVEL_W - 1,
    parameter int SPR_DIV      = 1,
    parameter int DRIP_DIV     = 2,
    parameter int FILL_DIV     = 1,
    parameter int CLEAN_CYCLES = 3,
    parameter int TIMEOUT      = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [ZONES-1:0]   req_spr,
    input  logic [ZONES-1:0]   req_drip,
    input  logic               fert,
    output logic [ZONES-1:0]   valve_open,
    output logic               mode,
    output logic               fill,
    output logic               clean,
    output logic [LEVEL_W-1:0] level,
    output logic [1:0]         state,
    output logic               error
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FILL  = 2'b01,
        ST_WATER = 2'b10,
        ST_CLEAN = 2'b11
    } state_t;

    localparam int PTR_W    = $clog2(ZONES);
    localparam int MAX_A    = (SPR_DIV > DRIP_DIV) ? SPR_DIV : DRIP_DIV;
    localparam int MAX_B    = (FILL_DIV > CLEAN_CYCLES) ? FILL_DIV : CLEAN_CYCLES;
    localparam int STEP_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int STEP_W   = $clog2(STEP_MAX + 1);
    localparam logic [LEVEL_W-1:0] LEVEL_FULL = {LEVEL_W{1'b1}};
    localparam logic [ZONES-1:0]   ONE_HOT0   = {{(ZONES-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [ZONES-1:0]   valve_q, valve_d;
    logic               mode_q, mode_d;
    logic               fill_q, fill_d;
    logic               clean_q, clean_d;
    logic               error_q, error_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic               fert_q, fert_d;
    logic               pend_q, pend_d;
    logic [STEP_W-1:0]  step_q, step_d;

    logic [ZONES-1:0]   valid_s;
    logic               conflict_s;
    logic               water_step_s;
    logic               timeout_s;
    logic               found_s;
    logic               hit_s;
    logic [PTR_W-1:0]   grant_s;
    logic [PTR_W-1:0]   cand_s;

    assign valid_s      = req_spr ^ req_drip;
    assign conflict_s   = |(req_spr & req_drip);
    assign water_step_s = mode_q ? (step_q == STEP_W'(SPR_DIV - 1))
                                 : (step_q == STEP_W'(DRIP_DIV - 1));

`ifdef IRRIG_TIMEOUT_EN
    localparam int GCNT_W = $clog2(TIMEOUT + 1);
    logic [GCNT_W-1:0] gcnt_q, gcnt_d;

    assign timeout_s = (state_q == ST_WATER) && (gcnt_q == GCNT_W'(TIMEOUT - 1));

    // Grant-length counter, zeroed whenever the controller is outside WATER.
    always_comb begin
        if (state_q == ST_WATER) begin
            gcnt_d = gcnt_q + GCNT_W'(1);
        end else begin
            gcnt_d = '0;
        end
    end

    // Grant-length counter register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            gcnt_q <= '0;
        end else begin
            gcnt_q <= gcnt_d;
        end
    end
`else
    logic unused_timeout_s;
    assign timeout_s        = 1'b0;
    assign unused_timeout_s = ^TIMEOUT;
`endif

    // Round-robin search: first valid zone after the pointer, wrapping modulo ZONES.
    always_comb begin
        found_s = 1'b0;
        hit_s   = 1'b0;
        grant_s = ptr_q;
        cand_s  = ptr_q;
        for (int i = 1; i <= ZONES; i++) begin
            cand_s  = PTR_W'((int'(ptr_q) + i) % ZONES);
            hit_s   = valid_s[cand_s] & ~found_s;
            grant_s = hit_s ? cand_s : grant_s;
            found_s = found_s | valid_s[cand_s];
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        valve_d = valve_q;
        mode_d  = mode_q;
        fill_d  = fill_q;
        clean_d = clean_q;
        ptr_d   = ptr_q;
        fert_d  = fert_q;
        pend_d  = pend_q;
        step_d  = step_q + STEP_W'(1);
        error_d = conflict_s | timeout_s;
        case (state_q)
            ST_IDLE: begin
                step_d = '0;
                if (level_q == '0) begin
                    state_d = ST_FILL;
                    fill_d  = 1'b1;
                end else if (pend_q) begin
                    state_d = ST_CLEAN;
                    clean_d = 1'b1;
                end else if (found_s) begin
                    state_d = ST_WATER;
                    valve_d = ONE_HOT0 << grant_s;
                    mode_d  = req_spr[grant_s];
                    fert_d  = fert;
                    ptr_d   = grant_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WATER: begin
                if (water_step_s) begin
                    step_d  = '0;
                    level_d = (level_q != '0) ? level_q - LEVEL_W'(1) : level_q;
                end else begin
                    level_d = level_q;
                end
                // Running dry wins over both timeout and release.
                if (water_step_s && (level_q == LEVEL_W'(1))) begin
                    state_d = ST_FILL;
                    fill_d  = 1'b1;
                    step_d  = '0;
                end else if (timeout_s || !valid_s[ptr_q]) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WATER;
                end
                if (state_d != ST_WATER) begin
                    valve_d = '0;
                    pend_d  = pend_q | (mode_q & fert_q);
                end else begin
                    valve_d = valve_q;
                end
            end
            ST_FILL: begin
                if (step_q == STEP_W'(FILL_DIV - 1)) begin
                    step_d  = '0;
                    level_d = (level_q != LEVEL_FULL) ? level_q + LEVEL_W'(1) : level_q;
                    if (level_d == LEVEL_FULL) begin
                        fill_d  = 1'b0;
                        clean_d = pend_q;
                        state_d = pend_q ? ST_CLEAN : ST_IDLE;
                    end else begin
                        state_d = ST_FILL;
                    end
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_CLEAN: begin
                if (step_q == STEP_W'(CLEAN_CYCLES - 1)) begin
                    clean_d = 1'b0;
                    pend_d  = 1'b0;
                    step_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_CLEAN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            level_q <= LEVEL_W'(LEVEL_INIT);
            valve_q <= '0;
            mode_q  <= 1'b0;
            fill_q  <= 1'b0;
            clean_q <= 1'b0;
            error_q <= 1'b0;
            ptr_q   <= PTR_W'(ZONES - 1);
            fert_q  <= 1'b0;
            pend_q  <= 1'b0;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            valve_q <= valve_d;
            mode_q  <= mode_d;
            fill_q  <= fill_d;
            clean_q <= clean_d;
            error_q <= error_d;
            ptr_q   <= ptr_d;
            fert_q  <= fert_d;
            pend_q  <= pend_d;
            step_q  <= step_d;
        end
    end

    assign valve_open = valve_q;
    assign mode       = mode_q;
    assign fill       = fill_q;
    assign clean      = clean_q;
    assign level      = level_q;
    assign state      = state_q;
    assign error      = error_q;

endmodule

// File: tb/tb_irrigation_zone_controller.sv
// Directed self-checking bench for irrigation_zone_controller with default parameters.
module tb_irrigation_zone_controller;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] req_spr;
    logic [3:0] req_drip;
    logic       fert;
    logic [3:0] valve_open;
    logic       mode;
    logic       fill;
    logic       clean;
    logic [2:0] level;
    logic [1:0] state;
    logic       error;

    int n_tests = 0;
    int n_fail  = 0;

    // Packed view: {state, level, valve_open, mode, fill, clean, error}
    logic [12:0] obs;
    logic [12:0] want;
    assign obs = {state, level, valve_open, mode, fill, clean, error};

    irrigation_zone_controller dut (
        .clock      (clock),
        .reset      (reset),
        .req_spr    (req_spr),
        .req_drip   (req_drip),
        .fert       (fert),
        .valve_open (valve_open),
        .mode       (mode),
        .fill       (fill),
        .clean      (clean),
        .level      (level),
        .state      (state),
        .error      (error)
    );

    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic restart;
        reset    = 1'b1;
        req_spr  = 4'b0000;
        req_drip = 4'b0000;
        fert     = 1'b0;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset    = 1'b1;
        req_spr  = 4'b0000;
        req_drip = 4'b0000;
        fert     = 1'b0;
        #1;
        want = {2'b00, 3'd7, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0};
        n_tests++;
        if (obs !== want) begin n_fail++; $display("FAIL reset_async: got %b want %b", obs, want); end
        tick(2);
        n_tests++;
        if (obs !== want) begin n_fail++; $display("FAIL reset_held: got %b want %b", obs, want); end
        reset = 1'b0;
    endtask

    task automatic test_drip_grant;
        restart();
        req_drip = 4'b0010;
        tick(1);
        want = {2'b10, 3'd7, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0};
        n_tests++;
        if (obs !== want) begin n_fail++; $display("FAIL drip_grant: got %b want %b", obs, want); end
        tick(2);
        want = {2'b10, 3'd6, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0};
        n_tests++;
        if (obs !== want) begin n_fail++; $display("FAIL drip_level6: got %b want %b", obs, want); end
        tick(2);
        want = {2'b10, 3'd5, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0};
        n_tests++;
        if (obs !== want) begin n_fail++; $display("FAIL drip_level5: got %b want %b", obs, want); end
        req_drip = 4'b0000;
        tick(1);
        want = {2'b00, 3'd5, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0};
        n_tests++;
        if (obs !== want) begin n_fail++; $display("FAIL drip_release: got %b want %b", obs, want); end
    endtask

    task automatic test_round_robin;
        restart();
        req_spr = 4'b1001;
        tick(1);
        want = {2'b10, 3'd7, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0};
        n_tests++;
        if (obs !== want) begin n_fail++; $display("FAIL rr_first_zone0: got %b want %b", obs, want); end
        req_spr = 4'b1000;
        tick(1);
        want = {2'b00, 3'd6, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0};
        n_tests++;
        if (obs !== want) begin n_fail++; $display("FAIL rr_release0: got %b want %b", obs, want); end
        req_spr = 4'b1001;
        tick(1);
        want = {2'b10, 3'd6, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b0};
        n_tests++;
        if (obs !== want) begin n_fail++; $display("FAIL rr_zone3_next: got %b want %b", obs, want); end
        req_spr = 4'b0000;
        tick(1);
        want = {2'b00, 3'd5, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0};
        n_tests++;
        if (obs !== want) begin n_fail++; $display("FAIL rr_release3: got %b want %b", obs, want); end
    endtask

    task automatic test_empty_tank;
        restart();
        req_spr = 4'b0100;
        tick(1);
        want = {2'b10, 3'd7, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0};
        n_tests++;
        if (obs !== want) begin n_fail++; $display("FAIL empty_grant: got %b want %b", obs, want); end
        tick(6);
        want = {2'b10, 3'd1, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0};
        n_tests++;
        if (obs !== want) begin n_fail++; $display("FAIL empty_level1: got %b want %b", obs, want); end
        tick(1);
        want = {2'b01, 3'd0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0};
        n_tests++;
        if (obs !== want) begin n_fail++; $display("FAIL empty_to_fill: got %b want %b", obs, want); end
        tick(6);
        want = {2'b01, 3'd6, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0};
        n_tests++;
        if (obs !== want) begin n_fail++; $display("FAIL fill_level6: got %b want %b", obs, want); end
        tick(1);
        want = {2'b00, 3'd7, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0};
        n_tests++;
        if (obs !== want) begin n_fail++; $display("FAIL fill_full_idle: got %b want %b", obs, want); end
        tick(1);
        want = {2'b10, 3'd7, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0};
        n_tests++;
        if (obs !== want) begin n_fail++; $display("FAIL empty_regrant: got %b want %b", obs, want); end
        req_spr = 4'b0000;
        tick(1);
    endtask

    task automatic test_conflict;
        restart();
        req_spr  = 4'b0010;
        req_drip = 4'b0011;
        tick(1);
        want = {2'b10, 3'd7, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b1};
        n_tests++;
        if (obs !== want) begin n_fail++; $display("FAIL conflict_grant0: got %b want %b", obs, want); end
        for (int i = 0; i < 4; i++) begin
            tick(1);
            n_tests++;
            if ({state, valve_open, error} !== {2'b10, 4'b0001, 1'b1}) begin
                n_fail++;
                $display("FAIL conflict_hold cycle %0d: got %b want %b", i, {state, valve_open, error}, 7'b1000011);
            end
        end
        req_drip = 4'b0010;
        for (int i = 0; i < 2; i++) begin
            tick(1);
            n_tests++;
            if ({state, valve_open, error} !== {2'b00, 4'b0000, 1'b1}) begin
                n_fail++;
                $display("FAIL conflict_no_zone1 cycle %0d: got %b want %b", i, {state, valve_open, error}, 7'b0000001);
            end
        end
        req_spr  = 4'b0000;
        req_drip = 4'b0000;
        tick(1);
        n_tests++;
        if (error !== 1'b0) begin n_fail++; $display("FAIL conflict_clear: got %b want 0", error); end
    endtask

    task automatic test_fert_clean;
        restart();
        fert    = 1'b1;
        req_spr = 4'b0001;
        tick(1);
        want = {2'b10, 3'd7, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0};
        n_tests++;
        if (obs !== want) begin n_fail++; $display("FAIL fert_grant: got %b want %b", obs, want); end
        req_spr = 4'b0000;
        fert    = 1'b0;
        tick(1);
        want = {2'b00, 3'd6, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0};
        n_tests++;
        if (obs !== want) begin n_fail++; $display("FAIL fert_idle_gap: got %b want %b", obs, want); end
        for (int i = 0; i < 3; i++) begin
            tick(1);
            want = {2'b11, 3'd6, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0};
            n_tests++;
            if (obs !== want) begin n_fail++; $display("FAIL fert_clean cycle %0d: got %b want %b", i, obs, want); end
        end
        tick(1);
        want = {2'b00, 3'd6, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0};
        n_tests++;
        if (obs !== want) begin n_fail++; $display("FAIL fert_clean_done: got %b want %b", obs, want); end
        tick(1);
        n_tests++;
        if (state !== 2'b00) begin n_fail++; $display("FAIL fert_pend_cleared: got %b want 00", state); end
    endtask

    task automatic test_fert_empty;
        restart();
        fert    = 1'b1;
        req_spr = 4'b0001;
        tick(8);
        want = {2'b01, 3'd0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0};
        n_tests++;
        if (obs !== want) begin n_fail++; $display("FAIL fe_fill_first: got %b want %b", obs, want); end
        req_spr = 4'b0000;
        fert    = 1'b0;
        tick(7);
        want = {2'b11, 3'd7, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0};
        n_tests++;
        if (obs !== want) begin n_fail++; $display("FAIL fe_clean_after_fill: got %b want %b", obs, want); end
        tick(3);
        want = {2'b00, 3'd7, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0};
        n_tests++;
        if (obs !== want) begin n_fail++; $display("FAIL fe_idle: got %b want %b", obs, want); end
    endtask

    task automatic test_reset_mid_water;
        restart();
        fert    = 1'b1;
        req_spr = 4'b0001;
        tick(3);
        want = {2'b10, 3'd5, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0};
        n_tests++;
        if (obs !== want) begin n_fail++; $display("FAIL rst_pre_water: got %b want %b", obs, want); end
        #2;
        reset = 1'b1;
        #1;
        want = {2'b00, 3'd7, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0};
        n_tests++;
        if (obs !== want) begin n_fail++; $display("FAIL rst_async_mid: got %b want %b", obs, want); end
        fert    = 1'b0;
        req_spr = 4'b0000;
        tick(1);
        reset = 1'b0;
        tick(2);
        n_tests++;
        if (state !== 2'b00) begin n_fail++; $display("FAIL rst_pend_lost: got %b want 00", state); end
    endtask

    initial begin
        test_reset();
        test_drip_grant();
        test_round_robin();
        test_empty_tank();
        test_conflict();
        test_fert_clean();
        test_fert_empty();
        test_reset_mid_water();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/irrigation_zone_controller.md
# irrigation_zone_controller

Multi-zone successor to the single-bed irrigation controller. It arbitrates per-zone sprinkler and drip requests round-robin, and tracks the reservoir level as an up/down counter. It drives the inlet valve to refill an empty tank and runs a post-fertiliser cleaning cycle. It sits between the debounced field inputs and the matrix display and valve drivers, on the divided slow clock.

## Interface
- ZONES, 4: number of zones; legal range 2..8.
- LEVEL_W, 3: width of the reservoir level counter; full = 2^LEVEL_W-1.
- LEVEL_INIT, 2^LEVEL_W-1: level loaded on reset.
- SPR_DIV, 1: WATER cycles per level unit consumed in sprinkler mode; must be ≥1.
- DRIP_DIV, 2: WATER cycles per level unit consumed in drip mode; must be ≥1.
- FILL_DIV, 1: FILL cycles per level unit added; must be ≥1.
- CLEAN_CYCLES, 3: length of the CLEAN state, in cycles; must be ≥1.
- TIMEOUT, 16: maximum WATER cycles per grant; used only with IRRIG_TIMEOUT_EN.
- clock  in  1  system clock (the divided slow clock).
- reset  in  1  asynchronous, active-high; clears all state.
- req_spr  in  ZONES  per-zone sprinkler request, level-sensitive.
- req_drip  in  ZONES  per-zone drip request, level-sensitive.
- fert  in  1  fertiliser present in the line.
- valve_open  out  ZONES  one-hot valve of the granted zone; all zero when no zone is granted.
- mode  out  1  1 = sprinkler, 0 = drip; meaningful only in WATER.
- fill  out  1  inlet valve open (the VE equivalent).
- clean  out  1  cleaning cycle active.
- level  out  LEVEL_W  current reservoir level.
- state  out  2  IDLE=00, FILL=01, WATER=10, CLEAN=11.
- error  out  1  registered fault flag.

## Operation
- All outputs are registered.
- Reset values:
  - state=IDLE, level=LEVEL_INIT.
  - valve_open, mode, fill, clean and error are 0.
  - The round-robin pointer is ZONES-1, so zone 0 has first priority.
  - clean_pend=0.
- Valid request for zone z: req_spr[z] XOR req_drip[z]. A zone with both bits set is invalid and is never granted.
- error <= |(req_spr & req_drip), evaluated every cycle in every state.
- IDLE:
  - If level==0, go to FILL. This check has priority over everything else.
  - Else if clean_pend, go to CLEAN.
  - Else grant the first valid zone found searching from pointer+1, wrapping modulo ZONES. Set pointer to that zone, latch mode=req_spr[z], and latch fert into an internal flag. Go to WATER.
- WATER:
  - valve_open holds the granted zone; the step counter counts cycles.
  - Every DIV cycles (SPR_DIV or DRIP_DIV, selected by mode), level decrements by 1.
  - Release: the granted zone's valid request is 0 in the current cycle. On the next edge, go to IDLE.
  - The edge where level goes from 1 to 0 goes to FILL. This overrides release.
  - When leaving WATER, if mode was sprinkler and the latched fert flag is set, set clean_pend.
  - A change of mode bits mid-grant is ignored. Only dropping to zero valid request releases the grant.
- FILL:
  - fill=1; requests are ignored.
  - level increments by 1 every FILL_DIV cycles.
  - The edge where level reaches full goes to CLEAN if clean_pend is set, otherwise to IDLE.
- CLEAN:
  - clean=1 for exactly CLEAN_CYCLES cycles; no water is consumed.
  - Then go to IDLE and clear clean_pend.
- level saturates: no decrement below 0, no increment above full.

## Timing
- Grant latency: a request that is valid in IDLE cycle t gives state=WATER and valve_open set after edge t+1.
- Release latency: one cycle. valve_open clears on the same edge that state leaves WATER.
- On every state entry, the step counter resets to 0. The first level change is DIV cycles after entry.
- On the edge where level becomes 0 in WATER, level=0, state=FILL, fill=1 and valve_open=0 all update together.
- Reset mid-operation: all outputs take their reset values immediately (asynchronous). Any grant and any pending clean are lost.
- A valve change is always preceded by a full cycle with valve_open=0, via IDLE. There is never a back-to-back zone handover.

## Configuration
- IRRIG_TIMEOUT_EN defined:
  - A grant counter limits WATER to TIMEOUT cycles.
  - At expiry the grant is force-released: state goes to IDLE, with normal clean_pend rules applied.
  - error pulses for one cycle.
  - The round-robin pointer advances, so a stuck zone cannot starve the others.
- IRRIG_TIMEOUT_EN not defined:
  - No grant counter exists, and TIMEOUT is ignored.
  - A grant lasts until release or until the tank is empty.

## Test plan
All scenarios use defaults (ZONES=4, LEVEL_W=3, LEVEL_INIT=7).
- Basic drip grant: hold req_drip=0010 after reset.
  - Next edge: WATER, valve_open=0010, mode=0.
  - level reads 6 after 2 cycles and 5 after 4.
  - Drop the request: IDLE and valve_open=0000 one edge later.
- Round robin: hold req_spr=1001.
  - Zone 0 is granted first.
  - After zone 0 releases and re-requests, zone 3 is granted before zone 0.
- Empty tank: hold req_spr=0100 with level=7.
  - level decrements once per cycle; the 7th edge gives level=0, FILL, fill=1, valve closed.
  - 7 cycles later level=7, then IDLE, then zone 2 is re-granted.
- Conflict: req_spr=0010 and req_drip=0011.
  - error=1 every cycle; zone 1 is never granted; zone 0 is granted in drip mode.
- Fertiliser cleaning: fert=1 at grant, sprinkler on zone 0, then release.
  - IDLE for one cycle, then CLEAN with clean=1 for 3 cycles, then IDLE.
  - If the tank empties during the grant, FILL runs first, then CLEAN.
- Reset mid-WATER: assert reset asynchronously.
  - Outputs are 0 and level=7 before the next clock edge.
  - With IRRIG_TIMEOUT_EN, a request held for 16 cycles is released and error pulses.
